// File: rtl/instr_encode_loader_pkg.sv
// Shared constants for the RV32I load/store/branch encoder and the
// decoder-side immediate generator: opcodes, bundle kinds, loader FSM states.
package instr_encode_loader_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        KIND_LOAD    = 2'd0,
        KIND_STORE   = 2'd1,
        KIND_BRANCH  = 2'd2,
        KIND_ILLEGAL = 2'd3
    } kind_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packer: builds the 32-bit RV32I word for a field bundle and
// flags bundles whose kind is illegal or whose immediate cannot be encoded.
module instr_field_pack
    import instr_encode_loader_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [1:0]   kind,
    input  logic [4:0]   rd,
    input  logic [4:0]   rs1,
    input  logic [4:0]   rs2,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] imm,
    output logic [N-1:0] word,
    output logic         illegal
);

    logic fits12_s;
    logic fits13_s;

    // Immediate fits when all bits above the field's sign bit copy the sign bit.
    always_comb begin
        fits12_s = (&imm[N-1:11]) | ~(|imm[N-1:11]);
        fits13_s = (&imm[N-1:12]) | ~(|imm[N-1:12]);
    end

    // Field placement per instruction format; branch offsets must be even.
    always_comb begin
        word    = {N{1'b0}};
        illegal = 1'b0;
        case (kind_e'(kind))
            KIND_LOAD: begin
                word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
                illegal = ~fits12_s;
            end
            KIND_STORE: begin
                word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
                illegal = ~fits12_s;
            end
            KIND_BRANCH: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
                illegal = ~fits13_s | imm[0];
            end
            default: begin
                word    = {N{1'b0}};
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Boot loader front end: encodes field bundles into RV32I words and streams
// them into imem at consecutive word addresses, counting rejected bundles.
module instr_encode_loader
    import instr_encode_loader_pkg::*;
#(
    parameter int N         = 32,
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        in_kind,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic [N-1:0]      in_imm,
    input  logic              in_last,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [N-1:0]      wr_data,
    output logic              err,
    output logic [7:0]        err_cnt,
    output logic              done
);

    localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

    state_e            state_r;
    logic              wr_valid_r;
    logic [ADDR_W-1:0] wr_addr_r;
    logic [N-1:0]      wr_data_r;
    logic              err_r;
    logic [7:0]        err_cnt_r;
    logic              done_r;

    logic [N-1:0]      word_s;
    logic              illegal_s;
    logic              in_ready_s;
    logic              accept_s;
    logic              wr_done_s;

    instr_field_pack #(.N(N)) u_pack (
        .kind    (in_kind),
        .rd      (in_rd),
        .rs1     (in_rs1),
        .rs2     (in_rs2),
        .funct3  (in_funct3),
        .imm     (in_imm),
        .word    (word_s),
        .illegal (illegal_s)
    );

    // Accept only while running and the output register is free or draining this cycle.
    always_comb begin
        if (state_r == ST_RUN) begin
            in_ready_s = ~wr_valid_r | wr_ready;
        end else begin
            in_ready_s = 1'b0;
        end
        accept_s  = in_valid & in_ready_s;
        wr_done_s = wr_valid_r & wr_ready;
    end

    // Loader FSM with output register, address counter and error counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            wr_valid_r <= 1'b0;
            wr_addr_r  <= BASE_A;
            wr_data_r  <= {N{1'b0}};
            err_r      <= 1'b0;
            err_cnt_r  <= 8'd0;
            done_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r   <= ST_RUN;
                        wr_addr_r <= BASE_A;
                        err_r     <= 1'b0;
                        err_cnt_r <= 8'd0;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (wr_done_s) begin
                        wr_valid_r <= 1'b0;
                        wr_addr_r  <= wr_addr_r + ADDR_STEP;
                    end
                    if (accept_s) begin
                        if (illegal_s) begin
                            err_r <= 1'b1;
                            if (err_cnt_r != 8'hFF) begin
                                err_cnt_r <= err_cnt_r + 8'd1;
                            end
                        end else begin
                            wr_valid_r <= 1'b1;
                            wr_data_r  <= word_s;
                        end
                        if (in_last) begin
                            state_r <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (wr_done_s) begin
                        wr_valid_r <= 1'b0;
                        wr_addr_r  <= wr_addr_r + ADDR_STEP;
                    end
                    if (!wr_valid_r || wr_done_s) begin
                        done_r  <= 1'b1;
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready = in_ready_s;
    assign wr_valid = wr_valid_r;
    assign wr_addr  = wr_addr_r;
    assign wr_data  = wr_data_r;
    assign err      = err_r;
    assign err_cnt  = err_cnt_r;
    assign done     = done_r;

endmodule

// File: tb/tb_instr_encode_loader.sv
// Randomized bench for instr_encode_loader against a queue-based model of
// the imem write stream, error count and done pulse.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, in_valid, in_last, wr_ready;
    logic [1:0]  in_kind;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic [31:0] in_imm;
    logic        in_ready, wr_valid, err, done;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic [7:0]  err_cnt;

    logic        w_start, w_in_valid, w_in_last, w_wr_ready;
    logic        w_in_ready, w_wr_valid, w_err, w_done;
    logic [3:0]  w_wr_addr;
    logic [31:0] w_wr_data;
    logic [7:0]  w_err_cnt;

    always #5 clk = ~clk;

    instr_encode_loader #(.N(32), .ADDR_W(10), .BASE_ADDR(0)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm), .in_last(in_last),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .err(err), .err_cnt(err_cnt), .done(done)
    );

    instr_encode_loader #(.N(32), .ADDR_W(4), .BASE_ADDR(12)) dut_w (
        .clk(clk), .rst_n(rst_n), .start(w_start), .in_valid(w_in_valid), .in_ready(w_in_ready),
        .in_kind(in_kind), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_imm(in_imm), .in_last(w_in_last),
        .wr_valid(w_wr_valid), .wr_ready(w_wr_ready), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
        .err(w_err), .err_cnt(w_err_cnt), .done(w_done)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, wanted %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: legality from signed ranges, encoding from field positions.
    function automatic logic legal_m(input logic [1:0] kind, input logic [31:0] imm);
        int s;
        s = int'($signed(imm));
        case (kind)
            2'd0, 2'd1: legal_m = (s >= -2048) && (s <= 2047);
            2'd2:       legal_m = (s >= -4096) && (s <= 4094) && (imm[0] == 1'b0);
            default:    legal_m = 1'b0;
        endcase
    endfunction

    function automatic logic [31:0] enc_m(input logic [1:0] kind, input logic [4:0] rd,
                                          input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [2:0] f3, input logic [31:0] imm);
        logic [31:0] common;
        common = (32'(rs1) << 15) | (32'(f3) << 12);
        case (kind)
            2'd0: enc_m = ((imm & 32'hFFF) << 20) | common | (32'(rd) << 7) | 32'h03;
            2'd1: enc_m = (((imm >> 5) & 32'h7F) << 25) | (32'(rs2) << 20) | common
                          | ((imm & 32'h1F) << 7) | 32'h23;
            2'd2: enc_m = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
                          | (32'(rs2) << 20) | common | (((imm >> 1) & 32'hF) << 8)
                          | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            default: enc_m = 32'h0;
        endcase
    endfunction

    typedef struct {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t  q[$];
    int   mode = 0;          // 0 idle, 1 running, 2 draining
    int   k = 0;             // legal words issued since start
    int   errc = 0;
    logic exp_done = 1'b0;
    int   dut_wr_cnt = 0;
    int   rdy_pct = 100;

    // Model advance on every rising edge using the pre-edge inputs.
    always @(posedge clk) begin
        logic comp;
        if (!rst_n) begin
            q.delete();
            mode = 0; k = 0; errc = 0; exp_done = 1'b0;
        end else begin
            if (wr_valid && wr_ready) dut_wr_cnt++;
            exp_done = 1'b0;
            comp = (q.size() != 0) && wr_ready;
            if (mode == 0) begin
                if (start) begin
                    mode = 1; k = 0; errc = 0;
                end
            end else if (mode == 1) begin
                if (comp) void'(q.pop_front());
                if (in_valid && (comp || q.size() == 0)) begin
                    if (legal_m(in_kind, in_imm)) begin
                        q.push_back('{addr: 10'(4 * k), data: enc_m(in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_imm)});
                        k++;
                    end else if (errc < 255) begin
                        errc++;
                    end else begin
                        errc = 255;
                    end
                    if (in_last) mode = 2;
                end
            end else begin
                if (q.size() == 0 || comp) begin
                    if (comp) void'(q.pop_front());
                    exp_done = 1'b1;
                    mode = 0;
                end
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("wr_valid", 32'(wr_valid), 32'(q.size() != 0));
            if (q.size() != 0) begin
                chk("wr_addr", 32'(wr_addr), 32'(q[0].addr));
                chk("wr_data", wr_data, q[0].data);
            end
            chk("in_ready", 32'(in_ready), 32'((mode == 1) && (q.size() == 0 || wr_ready)));
            chk("err", 32'(err), 32'(errc != 0));
            chk("err_cnt", 32'(err_cnt), 32'(errc));
            chk("done", 32'(done), 32'(exp_done));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        wr_ready = ($urandom_range(0, 99) < rdy_pct);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic send(input logic [1:0] kind, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [31:0] imm,
                        input logic last);
        logic acc;
        acc = 1'b0;
        in_valid = 1'b1; in_kind = kind; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_imm = imm; in_last = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) break;
        end
        if (!acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic wait_done();
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", 32'(seen), 32'd1);
        step();
    endtask

    int bnd[10] = '{2047, 2048, -2048, -2049, 4094, 4095, -4096, -4097, 4092, -2};

    function automatic logic [31:0] rand_imm();
        case ($urandom_range(0, 3))
            0:       rand_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
            1:       rand_imm = 32'(bnd[$urandom_range(0, 9)]);
            2:       rand_imm = $urandom;
            default: rand_imm = 32'($urandom_range(0, 63)) - 32'd32;
        endcase
    endfunction

    initial begin
        int base_cnt, n;
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; wr_ready = 1'b0;
        in_kind = 2'd0; in_rd = 5'd0; in_rs1 = 5'd0; in_rs2 = 5'd0; in_funct3 = 3'd0; in_imm = 32'd0;
        w_start = 1'b0; w_in_valid = 1'b0; w_in_last = 1'b0; w_wr_ready = 1'b0;

        chk("pin_load",   enc_m(2'd0, 5'd5, 5'd2, 5'd0, 3'd2, -32'sd4), 32'hFFC12283);
        chk("pin_store",  enc_m(2'd1, 5'd0, 5'd2, 5'd7, 3'd2, 32'd20),  32'h00712A23);
        chk("pin_branch", enc_m(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8), 32'hFE208CE3);
        chk("pin_legal",  {29'd0, legal_m(2'd0, 32'd2048), legal_m(2'd2, 32'd6), legal_m(2'd2, 32'd3)}, 32'h2);

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_wr_valid", 32'(wr_valid), 32'd0);
        chk("rst_wr_addr",  32'(wr_addr), 32'd0);
        chk("rst_wr_data",  wr_data, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_err",      {23'd0, err, err_cnt}, 32'd0);
        chk("rst_done",     32'(done), 32'd0);
        step();

        // Directed program from the test plan.
        rdy_pct = 100;
        pulse_start();
        send(2'd0, 5'd5, 5'd2, 5'd0, 3'd2, -32'sd4, 1'b0);
        send(2'd1, 5'd0, 5'd2, 5'd7, 3'd2, 32'd20, 1'b0);
        send(2'd2, 5'd0, 5'd1, 5'd2, 3'd0, -32'sd8, 1'b1);
        wait_done();

        // Rejections: three illegal bundles and one legal branch.
        base_cnt = dut_wr_cnt;
        pulse_start();
        send(2'd0, 5'd1, 5'd1, 5'd0, 3'd2, 32'd2048, 1'b0);
        send(2'd2, 5'd0, 5'd1, 5'd2, 3'd1, 32'd6, 1'b0);
        send(2'd2, 5'd0, 5'd1, 5'd2, 3'd1, 32'd3, 1'b0);
        send(2'd3, 5'd0, 5'd1, 5'd2, 3'd1, 32'd0, 1'b1);
        wait_done();
        chk("rej_err_cnt", 32'(err_cnt), 32'd3);
        chk("rej_err", 32'(err), 32'd1);
        chk("rej_writes", 32'(dut_wr_cnt - base_cnt), 32'd1);

        // Backpressure: write side stalled for several cycles with bundles waiting.
        pulse_start();
        rdy_pct = 0;
        fork
            begin
                send(2'd0, 5'd3, 5'd4, 5'd0, 3'd0, 32'd100, 1'b0);
                send(2'd1, 5'd0, 5'd4, 5'd6, 3'd1, -32'sd100, 1'b0);
                send(2'd2, 5'd0, 5'd4, 5'd6, 3'd5, 32'd64, 1'b1);
            end
            begin
                repeat (6) @(posedge clk);
                rdy_pct = 100;
            end
        join
        wait_done();

        // Saturating error counter.
        pulse_start();
        for (int i = 0; i < 260; i++) send(2'd3, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0, i == 259);
        wait_done();
        chk("sat_err_cnt", 32'(err_cnt), 32'd255);

        // Random programs with random write-side backpressure and gaps.
        for (int p = 0; p < 8; p++) begin
            rdy_pct = $urandom_range(30, 100);
            pulse_start();
            n = $urandom_range(1, 14);
            for (int b = 0; b < n; b++) begin
                if ($urandom_range(0, 3) == 0) step();
                start = ($urandom_range(0, 7) == 0);
                send(($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2)),
                     5'($urandom), 5'($urandom), 5'($urandom), 3'($urandom), rand_imm(), b == n - 1);
                start = 1'b0;
            end
            wait_done();
        end

        // Address wrap on a 4-bit address space starting at 12.
        in_kind = 2'd0; in_rd = 5'd1; in_rs1 = 5'd2; in_funct3 = 3'd2; in_imm = 32'd8;
        w_wr_ready = 1'b1;
        w_start = 1'b1;
        step();
        w_start = 1'b0; w_in_valid = 1'b1;
        @(negedge clk);
        chk("wrap_in_ready", 32'(w_in_ready), 32'd1);
        step();
        w_in_last = 1'b1;
        @(negedge clk);
        chk("wrap_first_valid", 32'(w_wr_valid), 32'd1);
        chk("wrap_first_addr", 32'(w_wr_addr), 32'd12);
        step();
        w_in_valid = 1'b0; w_in_last = 1'b0;
        @(negedge clk);
        chk("wrap_second_addr", 32'(w_wr_addr), 32'd0);
        chk("wrap_second_valid", 32'(w_wr_valid), 32'd1);
        step();
        @(negedge clk);
        chk("wrap_done", 32'(w_done), 32'd1);
        chk("wrap_after_addr", 32'(w_wr_addr), 32'd4);

        // Reset dropped while a write is stalled.
        step();
        rdy_pct = 0;
        pulse_start();
        send(2'd0, 5'd9, 5'd9, 5'd0, 3'd0, 32'd4, 1'b0);
        step();
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_wr_valid", 32'(wr_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd0);
        chk("arst_wr_addr", 32'(wr_addr), 32'd0);
        chk("arst_err_cnt", 32'(err_cnt), 32'd0);
        chk("arst_wr_data", wr_data, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        in_valid = 1'b1;
        @(negedge clk);
        chk("arst_idle_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_encode_loader.md
Name: instr_encode_loader

Overview:
- Inverse of the core's immediate generator: packs instruction fields plus a signed immediate into a 32-bit RV32I word for LOAD (0000011), STORE (0100011) and BRANCH (1100011).
- Streams the encoded words into instruction memory at consecutive word addresses.
- Used by the boot/test loader path that fills imem before the core leaves reset.
- Valid/ready on both sides; one-entry output register; a small FSM handles start, run and drain.

Parameters:
- N, 32, instruction/immediate width; only 32 is supported.
- ADDR_W, 10, imem byte-address width.
- BASE_ADDR, 0, byte address of the first word written after start.

Ports:
- clk  input  1  clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; arms the loader (ignored unless IDLE)
- in_valid  input  1  field bundle valid
- in_ready  output  1  bundle accepted when in_valid && in_ready
- in_kind  input  2  0=LOAD, 1=STORE, 2=BRANCH, 3=illegal
- in_rd  input  5  destination register (LOAD)
- in_rs1  input  5  base/source register 1
- in_rs2  input  5  source register 2 (STORE/BRANCH)
- in_funct3  input  3  funct3 field, passed through
- in_imm  input  N  signed immediate; the byte offset for BRANCH
- in_last  input  1  marks the final bundle of the program
- wr_valid  output  1  imem write request
- wr_ready  input  1  imem accepts the write
- wr_addr  output  ADDR_W  byte address, always a multiple of 4
- wr_data  output  N  encoded instruction
- err  output  1  sticky: at least one bundle rejected since start
- err_cnt  output  8  count of rejected bundles, saturates at 255
- done  output  1  one-cycle pulse when the program is fully written

Behaviour:
- Reset values: in_ready=0, wr_valid=0, wr_addr=BASE_ADDR, wr_data=0, err=0, err_cnt=0, done=0; FSM state is IDLE.
- FSM states:
  - IDLE: in_ready=0. start → RUN; on that transition wr_addr:=BASE_ADDR, err:=0, err_cnt:=0.
  - RUN: in_ready = !wr_valid || wr_ready. Accepting a bundle with in_last=1 → DRAIN.
  - DRAIN: in_ready=0. When the output register is empty, or its last word completes (wr_valid && wr_ready), pulse done for one cycle → IDLE.
- Encoding (combinational from the bundle; registered into wr_data on acceptance):
  - LOAD: {imm[11:0], rs1, funct3, rd, 0000011}.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
- Range check; a bundle is rejected when any of these holds:
  - LOAD/STORE: in_imm[31:11] not all equal (outside -2048..2047).
  - BRANCH: in_imm[31:12] not all equal (outside -4096..4094), or in_imm[0]=1.
  - in_kind=3.
- Rejected bundle: still consumed (handshake completes); no write issued; wr_addr not advanced; err:=1; err_cnt increments, saturating at 255. in_last on a rejected bundle still moves the FSM to DRAIN.
- Latency: one cycle. An accepted legal bundle appears on wr_valid/wr_data in the next cycle.
- Output register holds wr_valid/wr_addr/wr_data stable until wr_ready. Simultaneous completion of the held word and acceptance of a new bundle gives back-to-back writes (full throughput).
- wr_addr advances by 4 on each completed write; it wraps modulo 2^ADDR_W with no flag.
- start while in RUN or DRAIN is ignored.
- Asserting rst_n low mid-transfer immediately returns all outputs to reset values; a pending write is dropped.

Decomposition:
- Shared package:
  - opcode constants OP_LOAD=7'b0000011, OP_STORE=7'b0100011, OP_BRANCH=7'b1100011;
  - kind encodings KIND_LOAD/KIND_STORE/KIND_BRANCH/KIND_ILLEGAL;
  - FSM state encodings ST_IDLE/ST_RUN/ST_DRAIN.
- Package constants are shared with the decoder-side immediate generator.
- One natural sub-module: instr_field_pack. Purely combinational: kind, fields and imm in; word and illegal flag out.
- The top level keeps the FSM, output register, address counter and error counter.

Test Plan:
- Reset, start, then LOAD rd=5 rs1=2 funct3=2 imm=-4 → one cycle later wr_valid=1, wr_addr=0x000, wr_data=0xFFC12283. The immediate generator returns 0xFFFFFFFC.
- STORE rs1=2 rs2=7 funct3=2 imm=20 with wr_ready=1 → wr_data=0x00712A23, wr_addr=0x004. The immediate generator returns 0x00000014.
- BRANCH rs1=1 rs2=2 funct3=0 imm=-8 with last=1 → wr_data=0xFE208CE3. The immediate generator returns 0xFFFFFFFC (offset>>>1). done pulses after the write completes.
- Illegal cases: LOAD imm=2048, BRANCH imm=6 (legal), BRANCH imm=3, kind=3 → 3 rejections, 1 write, err=1, err_cnt=3; the address advances only once.
- Backpressure: hold wr_ready=0 for 5 cycles with 3 bundles pending → in_ready=0 while the register is full; wr_data/wr_addr stay stable. Releasing wr_ready gives 3 consecutive writes at +4 steps.
- Wrap/reset: ADDR_W=4, BASE_ADDR=12, write 2 words → addresses 12 then 0. Drop rst_n mid-stall → wr_valid=0 asynchronously; state returns to IDLE.
